hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO register pair for the single-cycle Minisys CPU. Sits directly downstream of the instruction decoder: consumes `HI_LO_write`, `HI_LO_move` and the raw opcode/function fields, takes operands from the register file, and returns `mfhi`/`mflo` data to the write-back mux. While a mult/div runs it asserts `Stall`, which freezes the PC and holds the current instruction until the result is committed.

---
 rtl/hilo_muldiv.sv | 169 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair
// of the single-cycle Minisys CPU. A mult/multu/div/divu takes 34 cycles:
// one accept cycle, 32 iteration cycles and one DONE cycle in which the
// stalled instruction retires. mthi/mtlo write HI/LO directly when idle.
//
// Ports:
//   clock            rising-edge system clock
//   reset            synchronous, active-low reset
//   Opcode           instruction [31:26]
//   Function_opcode  instruction [5:0]; [1:0] selects mult/multu/div/divu
//   HI_LO_write      decoder flag: start a mult/div
//   HI_LO_move       2'b10 = mfhi, 2'b01 = mflo, 2'b00 = none
//   Read_data_1      rs operand
//   Read_data_2      rt operand
//   HI_LO_data       HI or LO for mfhi/mflo, else 0 (combinational)
//   Stall            freezes PC / register-file write (combinational)
//   Hi, Lo           architectural HI and LO registers
module hilo_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Function_opcode,
  input  logic        HI_LO_write,
  input  logic [1:0]  HI_LO_move,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  output logic [31:0] HI_LO_data,
  output logic        Stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_isDiv;
  logic        r_negA;
  logic        r_negB;
  logic        r_divZero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic        w_negRs;
  logic        w_negRt;
  logic [31:0] w_magRs;
  logic [31:0] w_magRt;
  logic [32:0] w_mulSum;
  logic [63:0] w_mulNext;
  logic [32:0] w_divShift;
  logic [32:0] w_divDiff;
  logic [63:0] w_divNext;
  logic        w_signDiff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_mthi;
  logic        w_mtlo;

  // Operand magnitudes: signed ops (funct bit 0 clear) take absolute values,
  // and the signs are kept aside for the fix-up at the end.
  always_comb begin
    w_signed = ~Function_opcode[0];
    w_negRs  = w_signed & Read_data_1[31];
    w_negRt  = w_signed & Read_data_2[31];
    w_magRs  = w_negRs ? (32'd0 - Read_data_1) : Read_data_1;
    w_magRt  = w_negRt ? (32'd0 - Read_data_2) : Read_data_2;
    w_mthi   = (Opcode == 6'd0) && (Function_opcode == 6'b010001);
    w_mtlo   = (Opcode == 6'd0) && (Function_opcode == 6'b010011);
  end

  // One iteration of each algorithm on the shared 64-bit accumulator.
  // Multiply: upper half accumulates the multiplicand while the multiplier
  // shifts out of the lower half, LSB first. Divide: upper half is the
  // partial remainder (always below the divisor, so 32 bits suffice between
  // steps), lower half shifts the dividend out MSB first and the quotient in.
  always_comb begin
    w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_mulNext  = {w_mulSum, r_acc[31:1]};
    w_divShift = {r_acc[63:32], r_acc[31]};
    w_divDiff  = w_divShift - {1'b0, r_opnd};
    w_divNext  = w_divDiff[32] ? {w_divShift[31:0], r_acc[30:0], 1'b0}
                               : {w_divDiff[31:0],  r_acc[30:0], 1'b1};
  end

  // Sign fix-up of the final iteration's result. Divide by zero forces LO
  // to all ones; HI then naturally holds rs because the remainder equals
  // the dividend magnitude and gets rs's sign back.
  always_comb begin
    w_signDiff = r_negA ^ r_negB;
    w_prod     = w_signDiff ? (64'd0 - w_mulNext) : w_mulNext;
    w_quo      = r_divZero ? 32'hFFFF_FFFF
               : (w_signDiff ? (32'd0 - w_divNext[31:0]) : w_divNext[31:0]);
    w_rem      = r_negA ? (32'd0 - w_divNext[63:32]) : w_divNext[63:32];
  end

  // Main sequencer: accept in IDLE, iterate 32 times in BUSY committing
  // on the last edge, then spend one cycle in DONE so the still-present
  // instruction cannot restart the unit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_acc     <= 64'd0;
      r_opnd    <= 32'd0;
      r_isDiv   <= 1'b0;
      r_negA    <= 1'b0;
      r_negB    <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (HI_LO_write) begin
            r_isDiv   <= Function_opcode[1];
            r_negA    <= w_negRs;
            r_negB    <= w_negRt;
            r_divZero <= (Read_data_2 == 32'd0);
            r_opnd    <= Function_opcode[1] ? w_magRt : w_magRs;
            r_acc     <= {32'd0, (Function_opcode[1] ? w_magRs : w_magRt)};
            r_cnt     <= 6'd0;
            r_state   <= S_BUSY;
          end else if (w_mthi) begin
            r_hi <= Read_data_1;
          end else if (w_mtlo) begin
            r_lo <= Read_data_1;
          end
        end
        S_BUSY: begin
          r_acc <= r_isDiv ? w_divNext : w_mulNext;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_DONE;
            if (r_isDiv) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs: stall covers the accept cycle and all BUSY cycles; mfhi/mflo
  // read the registers as they stand this cycle.
  always_comb begin
    Stall = (r_state == S_BUSY) || ((r_state == S_IDLE) && HI_LO_write);
    Hi    = r_hi;
    Lo    = r_lo;
    case (HI_LO_move)
      2'b10:   HI_LO_data = r_hi;
      2'b01:   HI_LO_data = r_lo;
      default: HI_LO_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
// Self-checking bench for hilo_muldiv: directed cases plus randomized
// mult/div operations compared against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic [5:0]  Function_opcode;
  logic        HI_LO_write;
  logic [1:0]  HI_LO_move;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic [31:0] HI_LO_data;
  logic        Stall;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv dut (
    .clock(clock),
    .reset(reset),
    .Opcode(Opcode),
    .Function_opcode(Function_opcode),
    .HI_LO_write(HI_LO_write),
    .HI_LO_move(HI_LO_move),
    .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2),
    .HI_LO_data(HI_LO_data),
    .Stall(Stall),
    .Hi(Hi),
    .Lo(Lo)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Safety net so the run always ends even if the DUT wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    p  = 64'd0;
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, rs} * {32'd0, rt};
      2'd2: begin
        if (rt == 32'd0) p = {rs, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (rt == 32'd0) p = {rs, 32'hFFFF_FFFF};
        else p = {rs % rt, rs / rt};
      end
    endcase
    return p;
  endfunction

  // Runs one mult/div with HI_LO_write held through DONE, checks stall
  // length, the committed HI/LO, mflo/mfhi reads and that no restart occurs.
  // Called just after a rising edge.
  task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] rs,
                               input logic [31:0] rt, input string tag);
    logic [63:0] e;
    int          n;
    e               = refModel(funct[1:0], rs, rt);
    Opcode          = 6'd0;
    Function_opcode = funct;
    HI_LO_write     = 1'b1;
    HI_LO_move      = 2'b00;
    Read_data_1     = rs;
    Read_data_2     = rt;
    #1 checkOutput({tag, " stall_accept"}, 32'(Stall), 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (!Stall) break;
      n++;
      Read_data_1 = $urandom;
      Read_data_2 = $urandom;
    end
    checkOutput({tag, " busy_cycles"}, 32'(n), 32'd32);
    checkOutput({tag, " hi"}, Hi, e[63:32]);
    checkOutput({tag, " lo"}, Lo, e[31:0]);
    @(posedge clock);
    #1;
    HI_LO_write = 1'b0;
    HI_LO_move  = 2'b01;
    #1 checkOutput({tag, " mflo"}, HI_LO_data, e[31:0]);
    HI_LO_move  = 2'b10;
    #1 checkOutput({tag, " mfhi"}, HI_LO_data, e[63:32]);
    HI_LO_move  = 2'b00;
    @(posedge clock);
    #1 checkOutput({tag, " no_restart"}, 32'(Stall), 32'd0);
  endtask

  initial begin
    logic [31:0] rs, rt;
    logic [5:0]  f;

    $display("[TB] start");
    reset           = 1'b0;
    Opcode          = 6'd0;
    Function_opcode = 6'd0;
    HI_LO_write     = 1'b0;
    HI_LO_move      = 2'b00;
    Read_data_1     = 32'd0;
    Read_data_2     = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset hi", Hi, 32'd0);
    checkOutput("reset lo", Lo, 32'd0);
    checkOutput("reset stall", 32'(Stall), 32'd0);
    HI_LO_write = 1'b1;
    #1 checkOutput("reset stall_eq_write", 32'(Stall), 32'd1);
    HI_LO_write = 1'b0;
    HI_LO_move  = 2'b10;
    #1 checkOutput("reset mfhi", HI_LO_data, 32'd0);
    HI_LO_move  = 2'b01;
    #1 checkOutput("reset mflo", HI_LO_data, 32'd0);
    HI_LO_move  = 2'b00;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Directed arithmetic cases, including sign and divide-by-zero corners.
    applyStimulus(6'b011001, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    applyStimulus(6'b011000, 32'hFFFF_FFFD, 32'd5, "mult_m3_x5");
    applyStimulus(6'b011000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "mult_m4_xm4");
    applyStimulus(6'b011010, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    applyStimulus(6'b011011, 32'd100, 32'd7, "divu_100_7");
    applyStimulus(6'b011011, 32'd7, 32'd0, "divu_7_0");
    applyStimulus(6'b011010, 32'hFFFF_FFF8, 32'd0, "div_m8_0");
    applyStimulus(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");

    // mthi / mtlo write directly and never stall.
    Function_opcode = 6'b010001;
    Read_data_1     = 32'hDEAD_BEEF;
    #1 checkOutput("mthi stall", 32'(Stall), 32'd0);
    @(posedge clock);
    #1;
    Function_opcode = 6'b010000;
    HI_LO_move      = 2'b10;
    #1 checkOutput("mthi mfhi", HI_LO_data, 32'hDEAD_BEEF);
    checkOutput("mfhi stall", 32'(Stall), 32'd0);
    Function_opcode = 6'b010011;
    HI_LO_move      = 2'b00;
    Read_data_1     = 32'h1234_5678;
    @(posedge clock);
    #1;
    Function_opcode = 6'b010010;
    HI_LO_move      = 2'b01;
    #1 checkOutput("mtlo mflo", HI_LO_data, 32'h1234_5678);
    checkOutput("mtlo hi_kept", Hi, 32'hDEAD_BEEF);
    HI_LO_move = 2'b00;
    @(posedge clock);
    #1;

    // Reset in the middle of an operation aborts with HI/LO cleared.
    Function_opcode = 6'b011001;
    HI_LO_write     = 1'b1;
    Read_data_1     = 32'h0001_0000;
    Read_data_2     = 32'h0001_0000;
    repeat (10) @(posedge clock);
    #1 checkOutput("midreset busy", 32'(Stall), 32'd1);
    reset       = 1'b0;
    HI_LO_write = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midreset stall", 32'(Stall), 32'd0);
    checkOutput("midreset hi", Hi, 32'd0);
    checkOutput("midreset lo", Lo, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1 checkOutput("midreset idle", 32'(Stall), 32'd0);

    // Randomized operations with a mix of operand shapes.
    for (int k = 0; k < 12; k++) begin
      f  = {4'b0110, 2'($urandom_range(0, 3))};
      rs = $urandom;
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = $urandom_range(1, 300);
        2:       rt = 32'd0 - 32'($urandom_range(1, 300));
        default: rt = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) rs = $urandom_range(0, 5000);
      applyStimulus(f, rs, rt, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
